prg_load_arbiter: RTL and testbench
===================================

Name: prg_load_arbiter

Overview:
- Shares the cartridge PRG SRAM between the console CPU bus and a host-side loader that downloads ROM images into RAM.
- Runs on osc50.
- Tracks M2 phase via a synchroniser and slots loader read/write cycles into the M2-low window, where the CPU never drives ROMSEL-qualified accesses.
- Drives an SRAM-side pin mux select plus its own SRAM strobes; the CPU path is pass-through whenever the arbiter is idle.

Parameters:
- ADDR_W, 22, SRAM byte address width (matches PRG address bits 21:0).
- STROBE_CYCLES, 3, osc50 cycles the OE/WE strobe is held low per loader access.
- GUARD_CYCLES, 2, osc50 cycles after the synchronised M2 fall before a loader access may start.
- LAST_START, 8, largest M2-low count at which a loader access may still start.
- CNT_W, 8, width of the M2-low counter (saturating).

Ports:
- osc50  in  1  system clock, 50 MHz
- m2_rst  in  1  reset, synchronous, active-high
- m2  in  1  raw CPU M2, asynchronous to osc50
- host_mode  in  1  1 = console held off; loader owns SRAM unconditionally
- load_req  in  1  loader request; held until load_ack or load_err
- load_we  in  1  1 = write, 0 = read; sampled at accept
- load_addr  in  ADDR_W  SRAM address; sampled at accept
- load_wdata  in  8  write data; sampled at accept
- load_ack  out  1  one-cycle pulse: access completed
- load_err  out  1  one-cycle pulse: access aborted by M2 rise
- load_rdata  out  8  read data; valid with load_ack for reads, held until the next read
- cpu_grant  out  1  1 = SRAM pins follow the CPU path; 0 = the arbiter's pins drive
- sram_addr  out  ADDR_W  loader address to the SRAM
- sram_dout  out  8  loader write data
- sram_dout_en  out  1  loader data bus output enable
- sram_din  in  8  SRAM data bus read-back
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  loader-side strobes, active-low

Behaviour:
- Reset: FSM = IDLE, cpu_grant = 1, all strobes = 1, sram_dout_en = 0, load_ack = 0, load_err = 0, load_rdata = 0, sram_addr = 0, sram_dout = 0, low_cnt = 0, M2 synchroniser flops = 1.
- M2 sync: 2-flop synchroniser gives m2_s. low_cnt clears to 0 while m2_s = 1 and increments while m2_s = 0, saturating at 2^CNT_W-1.
- window_ok = host_mode OR (m2_s = 0 AND GUARD_CYCLES <= low_cnt <= LAST_START).
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: if load_req AND window_ok, latch addr/we/wdata, set cpu_grant = 0, sram_ce_n = 0, sram_dout_en = load_we, and go to SETUP. Otherwise cpu_grant = host_mode ? 0 : 1.
  - SETUP (1 cycle): address and CE stable. Go to STROBE; assert sram_we_n = 0 (write) or sram_oe_n = 0 (read). Load the strobe counter with STROBE_CYCLES-1.
  - STROBE: count down. At 0: deassert the strobe; for reads, capture sram_din into load_rdata. Go to HOLD.
  - HOLD (1 cycle): CE and data still driven. Pulse load_ack. Then CE = 1, sram_dout_en = 0, go to IDLE. cpu_grant returns to 1 on the IDLE cycle unless host_mode = 1.
- Latency: accept to load_ack = STROBE_CYCLES + 2 cycles (5 at default).
- Requests are serviced in issue order only; no queueing. A new access may start on the IDLE cycle right after HOLD if the window still allows it.
- Abort: if m2_s rises while in SETUP/STROBE/HOLD and host_mode = 0:
  - next cycle: all strobes = 1, sram_dout_en = 0, load_err pulses, go to IDLE, cpu_grant = 1;
  - load_rdata is not updated; the loader must retry.
- host_mode toggled mid-access: the current access completes normally. The new mode applies from the next IDLE decision.
- Write-data and address registers hold their value outside accesses; only the strobes gate SRAM writes.
- load_req dropped mid-access is ignored; the access completes.
- m2_rst during an access: immediate return to reset values the next edge; no ack/err pulse.

Decomposition:
- Shared package fc_cart_pkg:
  - arb_state_t enum {IDLE, SETUP, STROBE, HOLD};
  - PRG_ADDR_W = 22;
  - default timing constants.
- Sub-module m2_phase_tracker: synchroniser + saturating low_cnt + window_ok, reused by later CHR-side loaders.

Test Plan:
1. host_mode = 1, write 0x5A to 0x000123 -> SETUP/STROBE/HOLD. sram_we_n low exactly 3 cycles, addr = 0x000123, dout = 0x5A. load_ack at cycle 5 after accept.
2. host_mode = 0, M2 period 28 cycles (14 high / 14 low). Request during M2 high -> no start until low_cnt = 2. Access ends before M2 rises, load_ack asserted, cpu_grant back to 1 before m2_s rises.
3. Request arriving at low_cnt = 9 (> LAST_START) -> deferred to the next M2-low window; starts at low_cnt = 2.
4. Read 0x3FFFFF with sram_din = 0xC3 -> load_rdata = 0xC3 with load_ack; sram_oe_n low for 3 cycles, sram_we_n stays 1.
5. Shortened M2 low phase: m2_s rises during STROBE -> strobes high the next cycle, load_err pulse, no load_ack, load_rdata unchanged.
6. m2_rst asserted in STROBE -> next cycle all outputs at reset values, cpu_grant = 1, no ack/err pulse.

Source files
------------

// File: rtl/fc_cart_pkg.sv
// Shared cartridge-side types and default timing for the PRG/CHR SRAM loaders.
package fc_cart_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} arb_state_t;

  localparam int unsigned PRG_ADDR_W        = 22;
  localparam int unsigned DEF_STROBE_CYCLES = 3;
  localparam int unsigned DEF_GUARD_CYCLES  = 2;
  localparam int unsigned DEF_LAST_START    = 8;
  localparam int unsigned DEF_CNT_W         = 8;

endpackage

// File: rtl/m2_phase_tracker.sv
// Synchronises CPU M2 into the osc50 domain and flags the M2-low window in which
// a loader access may safely start.
module m2_phase_tracker
  import fc_cart_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int unsigned LAST_START   = DEF_LAST_START
) (
  input  logic clk,
  input  logic rst,
  input  logic m2,
  input  logic host_mode,
  output logic m2_s,
  output logic window_ok
);

  localparam logic [CNT_W-1:0] GuardCnt = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(LAST_START);

  logic             m2_meta_q, m2_s_q;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;

  always_comb begin
    low_cnt_d = low_cnt_q;
    if (m2_s_q) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != {CNT_W{1'b1}}) begin
      low_cnt_d = low_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m2_meta_q <= 1'b1;
      m2_s_q    <= 1'b1;
      low_cnt_q <= '0;
    end else begin
      m2_meta_q <= m2;
      m2_s_q    <= m2_meta_q;
      low_cnt_q <= low_cnt_d;
    end
  end

  assign m2_s      = m2_s_q;
  assign window_ok = host_mode | (~m2_s_q & (low_cnt_q >= GuardCnt) & (low_cnt_q <= LastCnt));

endmodule

// File: rtl/prg_load_arbiter.sv
// Arbitrates the cartridge PRG SRAM between the CPU bus and a host ROM loader,
// slotting loader cycles into the M2-low window (or anywhere in host mode).
module prg_load_arbiter
  import fc_cart_pkg::*;
#(
  parameter int unsigned ADDR_W        = PRG_ADDR_W,
  parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int unsigned GUARD_CYCLES  = DEF_GUARD_CYCLES,
  parameter int unsigned LAST_START    = DEF_LAST_START,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic              osc50,
  input  logic              m2_rst,
  input  logic              m2,
  input  logic              host_mode,
  input  logic              load_req,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_wdata,
  output logic              load_ack,
  output logic              load_err,
  output logic [7:0]        load_rdata,
  output logic              cpu_grant,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  output logic              sram_dout_en,
  input  logic [7:0]        sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int unsigned SC_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [SC_W-1:0] StrobeLoad = SC_W'(STROBE_CYCLES - 1);

  logic m2_s, window_ok;

  m2_phase_tracker #(
    .CNT_W       (CNT_W),
    .GUARD_CYCLES(GUARD_CYCLES),
    .LAST_START  (LAST_START)
  ) u_m2_phase_tracker (
    .clk      (osc50),
    .rst      (m2_rst),
    .m2       (m2),
    .host_mode(host_mode),
    .m2_s     (m2_s),
    .window_ok(window_ok)
  );

  arb_state_t        state_q, state_d;
  logic [SC_W-1:0]   scnt_q, scnt_d;
  logic              we_lat_q, we_lat_d;
  logic              host_lat_q, host_lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              dout_en_q, dout_en_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic              ack_q, ack_d, err_q, err_d, grant_q, grant_d;

  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    we_lat_d   = we_lat_q;
    host_lat_d = host_lat_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    rdata_d    = rdata_q;
    dout_en_d  = dout_en_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    grant_d    = grant_q;

    if (state_q == IDLE) begin
      if (load_req && window_ok) begin
        addr_d     = load_addr;
        dout_d     = load_wdata;
        we_lat_d   = load_we;
        host_lat_d = host_mode;
        grant_d    = 1'b0;
        ce_n_d     = 1'b0;
        dout_en_d  = load_we;
        state_d    = SETUP;
      end else begin
        grant_d = ~host_mode;
      end
    // Mode is latched at accept so a mid-access host_mode change never aborts.
    end else if (!host_lat_q && m2_s) begin
      ce_n_d    = 1'b1;
      oe_n_d    = 1'b1;
      we_n_d    = 1'b1;
      dout_en_d = 1'b0;
      err_d     = 1'b1;
      grant_d   = 1'b1;
      state_d   = IDLE;
    end else begin
      unique case (state_q)
        SETUP: begin
          if (we_lat_q) we_n_d = 1'b0;
          else          oe_n_d = 1'b0;
          scnt_d  = StrobeLoad;
          state_d = STROBE;
        end
        STROBE: begin
          if (scnt_q == '0) begin
            we_n_d = 1'b1;
            oe_n_d = 1'b1;
            if (!we_lat_q) rdata_d = sram_din;
            state_d = HOLD;
          end else begin
            scnt_d = scnt_q - SC_W'(1);
          end
        end
        HOLD: begin
          ack_d     = 1'b1;
          ce_n_d    = 1'b1;
          dout_en_d = 1'b0;
          grant_d   = ~host_mode;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge osc50) begin
    if (m2_rst) begin
      state_q    <= IDLE;
      scnt_q     <= '0;
      we_lat_q   <= 1'b0;
      host_lat_q <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      rdata_q    <= '0;
      dout_en_q  <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      grant_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      we_lat_q   <= we_lat_d;
      host_lat_q <= host_lat_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      rdata_q    <= rdata_d;
      dout_en_q  <= dout_en_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      grant_q    <= grant_d;
    end
  end

  assign load_ack     = ack_q;
  assign load_err     = err_q;
  assign load_rdata   = rdata_q;
  assign cpu_grant    = grant_q;
  assign sram_addr    = addr_q;
  assign sram_dout    = dout_q;
  assign sram_dout_en = dout_en_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;

endmodule

// File: tb/tb_prg_load_arbiter.sv
// Directed bench for prg_load_arbiter: host-mode and M2-windowed accesses, deferral,
// read capture, M2-rise abort and reset mid-access.
module tb_prg_load_arbiter;

  logic        osc50 = 1'b0;
  logic        m2_rst, m2, host_mode, load_req, load_we;
  logic [21:0] load_addr;
  logic [7:0]  load_wdata, sram_din;
  logic        load_ack, load_err, cpu_grant, sram_dout_en;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [7:0]  load_rdata, sram_dout;
  logic [21:0] sram_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int acc, ack, err, we_lo, oe_lo, den;

  prg_load_arbiter dut (
    .osc50       (osc50),
    .m2_rst      (m2_rst),
    .m2          (m2),
    .host_mode   (host_mode),
    .load_req    (load_req),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_wdata  (load_wdata),
    .load_ack    (load_ack),
    .load_err    (load_err),
    .load_rdata  (load_rdata),
    .cpu_grant   (cpu_grant),
    .sram_addr   (sram_addr),
    .sram_dout   (sram_dout),
    .sram_dout_en(sram_dout_en),
    .sram_din    (sram_din),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n)
  );

  always #5 osc50 = ~osc50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge osc50);
    @(negedge osc50);
  endtask

  // Ticks up to bound cycles; records first CE-low tick, ack/err tick and strobe widths.
  task automatic run(input int bound);
    acc = -1; ack = -1; err = -1; we_lo = 0; oe_lo = 0; den = 0;
    for (int t = 1; t <= bound; t++) begin
      tick();
      if (acc < 0 && !sram_ce_n) acc = t;
      if (!sram_we_n) we_lo++;
      if (!sram_oe_n) oe_lo++;
      if (sram_dout_en) den++;
      if (load_ack && ack < 0) ack = t;
      if (load_err && err < 0) err = t;
      if (load_ack || load_err) begin
        load_req = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    m2_rst = 1'b1; m2 = 1'b1; host_mode = 1'b0; load_req = 1'b0; load_we = 1'b0;
    load_addr = '0; load_wdata = '0; sram_din = 8'hC3;
    tick(); tick();
    chk("rst_grant", 32'(cpu_grant), 32'd1);
    chk("rst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    chk("rst_misc", {28'd0, sram_dout_en, load_ack, load_err, 1'b0}, 32'd0);
    chk("rst_regs", {sram_addr, sram_dout}, 32'd0);
    chk("rst_rdata", 32'(load_rdata), 32'd0);
    m2_rst = 1'b0;

    // 1: host-mode write
    host_mode = 1'b1; load_req = 1'b1; load_we = 1'b1;
    load_addr = 22'h000123; load_wdata = 8'h5A;
    run(12);
    chk("t1_accept", acc, 1);
    chk("t1_ack", ack, 6);
    chk("t1_we_width", we_lo, 3);
    chk("t1_oe_width", oe_lo, 0);
    chk("t1_dout_en", den, 5);
    chk("t1_addr", 32'(sram_addr), 32'h123);
    chk("t1_dout", 32'(sram_dout), 32'h5A);
    chk("t1_grant", 32'(cpu_grant), 32'd0);

    // 2: windowed write, request raised while M2 high
    host_mode = 1'b0; load_req = 1'b1; load_addr = 22'h000456; load_wdata = 8'hA5;
    run(4);
    chk("t2_no_start_high", acc, -1);
    chk("t2_grant_idle", 32'(cpu_grant), 32'd1);
    m2 = 1'b0;
    run(20);
    chk("t2_accept", acc, 5);
    chk("t2_ack", ack, 10);
    chk("t2_err", err, -1);
    chk("t2_grant_back", 32'(cpu_grant), 32'd1);
    chk("t2_addr", 32'(sram_addr), 32'h456);
    run(4);
    m2 = 1'b1;
    run(14);

    // 3: request arrives at low_cnt = 9, must wait for the next window
    m2 = 1'b0;
    run(11);
    load_req = 1'b1; load_we = 1'b1; load_addr = 22'h000789; load_wdata = 8'h77;
    run(3);
    chk("t3_late_low", acc, -1);
    m2 = 1'b1;
    run(14);
    chk("t3_during_high", acc, -1);
    m2 = 1'b0;
    run(20);
    chk("t3_accept", acc, 5);
    chk("t3_ack", ack, 10);
    chk("t3_dout", 32'(sram_dout), 32'h77);
    m2 = 1'b1;
    run(14);

    // 4: read from top address
    load_req = 1'b1; load_we = 1'b0; load_addr = 22'h3FFFFF; sram_din = 8'hC3;
    m2 = 1'b0;
    run(20);
    chk("t4_accept", acc, 5);
    chk("t4_ack", ack, 10);
    chk("t4_rdata", 32'(load_rdata), 32'hC3);
    chk("t4_oe_width", oe_lo, 3);
    chk("t4_we_width", we_lo, 0);
    chk("t4_dout_en", den, 0);
    chk("t4_addr", 32'(sram_addr), 32'h3FFFFF);
    m2 = 1'b1;
    run(14);

    // 5: M2 rises during STROBE -> abort
    load_req = 1'b1; load_we = 1'b0; load_addr = 22'h000010; sram_din = 8'h3C;
    m2 = 1'b0;
    run(5);
    chk("t5_accept", acc, 5);
    m2 = 1'b1;
    run(10);
    chk("t5_err", err, 3);
    chk("t5_no_ack", ack, -1);
    chk("t5_oe_width", oe_lo, 2);
    chk("t5_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    chk("t5_dout_en", 32'(sram_dout_en), 32'd0);
    chk("t5_grant", 32'(cpu_grant), 32'd1);
    chk("t5_rdata_kept", 32'(load_rdata), 32'hC3);
    run(3);
    chk("t5_quiet", {ack, err}, {-32'sd1, -32'sd1});

    // 6: reset while in STROBE
    host_mode = 1'b1; load_req = 1'b1; load_we = 1'b1;
    load_addr = 22'h2AAAAA; load_wdata = 8'h96;
    run(3);
    chk("t6_accept", acc, 1);
    chk("t6_in_strobe", 32'(sram_we_n), 32'd0);
    load_req = 1'b0; m2_rst = 1'b1;
    tick();
    chk("t6_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    chk("t6_grant", 32'(cpu_grant), 32'd1);
    chk("t6_regs", {sram_addr, sram_dout}, 32'd0);
    chk("t6_rdata", 32'(load_rdata), 32'd0);
    chk("t6_flags", {29'd0, sram_dout_en, load_ack, load_err}, 32'd0);
    run(3);
    chk("t6_no_pulse", {ack, err}, {-32'sd1, -32'sd1});
    m2_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
